alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the 32-bit MIPS ALU. Captures the ALU result, the O/C/Z/S flags and the writeback/memory control for one instruction.
- Hands the captured bundle to the memory stage over a valid/ready handshake.
- A two-entry skid buffer keeps full throughput with registered ready; also keeps a sticky status register and a retired-instruction counter.

Parameters:
- DATA_W, 32, width of ALU result, store data and PC
- REG_ADDR_W, 5, destination register index width
- CNT_W, 32, retired-instruction counter width

Ports:
- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous kill of all held entries
- InValid  in  1  upstream bundle valid
- InReady  out  1  stage can accept a bundle; registered
- ALUOut  in  DATA_W  ALU result
- FlagsIn  in  4  {O,C,Z,S} from ALU
- StoreDataIn  in  DATA_W  rt value for stores
- PCIn  in  DATA_W  instruction PC
- RdIn  in  REG_ADDR_W  destination register
- CtrlIn  in  4  {TrapOvf,MemWrite,MemRead,RegWrite}
- OutValid  out  1  downstream bundle valid
- OutReady  in  1  downstream accepts
- ResultOut, StoreDataOut, PCOut  out  DATA_W  held bundle fields
- FlagsOut  out  4  held flags
- RdOut  out  REG_ADDR_W  held destination
- CtrlOut  out  3  {MemWrite,MemRead,RegWrite}, possibly suppressed by the optional feature
- StickyFlags  out  4  OR of FlagsOut over all retired bundles
- RetireCount  out  CNT_W  number of retired bundles

Behaviour:
- Reset (Reset_n low, asynchronous):
  - OutValid=0, skid entry empty, InReady=1.
  - StickyFlags=0, RetireCount=0; all data outputs 0.
- Handshake events:
  - Accept = InValid & InReady.
  - Retire = OutValid & OutReady.
- Storage: main register M (drives outputs) and skid register K. Zero added latency beyond the register: an accepted bundle is visible on outputs the next cycle.
- State machine over {M.v, K.v}: EMPTY(0,0), ONE(1,0), FULL(1,1).
  - EMPTY: Accept -> load M -> ONE.
  - ONE:
    - Accept & Retire -> load M -> ONE.
    - Accept & !Retire -> load K -> FULL.
    - !Accept & Retire -> EMPTY.
  - FULL: Retire -> M<=K, K empty -> ONE. InReady=0 in FULL, so no Accept is possible there.
- InReady next = !(next state == FULL).
- Ordering: bundles retire in accept order; K is never bypassed.
- Flush (highest priority, synchronous):
  - Next state EMPTY, InReady=1.
  - A bundle accepted in the same cycle is dropped.
  - A bundle retired in the same cycle still counts, since the downstream already took it.
  - StickyFlags and RetireCount are not cleared by Flush.
- On Retire: StickyFlags |= FlagsOut; RetireCount += 1, wrapping modulo 2^CNT_W with no saturation.
- Output fields hold stable while OutValid=1 and OutReady=0.
- Reset asserted mid-transfer discards all entries; the counter and sticky register clear.

Optional Feature:
- Macro OVF_TRAP_EN.
- Defined:
  - Adds outputs OvfTrap (1) and TrapPC (DATA_W).
  - When a bundle is loaded into M (directly or from K) with TrapOvf=1 and O=1: its CtrlOut RegWrite/MemWrite/MemRead are forced to 0.
  - On that bundle's Retire cycle, OvfTrap pulses for one cycle and TrapPC <= PCOut.
  - TrapPC holds until the next trap. Reset value: OvfTrap=0, TrapPC=0.
- Undefined: ports absent; TrapOvf is ignored and CtrlOut passes through unchanged.

Test Plan:
- Reset then a single bundle (ALUOut=0x0000_0005, Rd=3, RegWrite=1, OutReady=1) -> OutValid=1 one cycle later with ResultOut=5, RdOut=3; RetireCount=1 after retire.
- Back-to-back stream of 8 bundles (values 1..8) with OutReady held 1 -> one retire per cycle, InReady never drops, outputs 1..8 in order.
- Send A=0x11 then B=0x22 with OutReady=0 -> state FULL, InReady=0, outputs hold 0x11; raise OutReady -> 0x11 then 0x22 retire in order, InReady=1 again.
- In FULL, assert Flush together with InValid (C=0x33) -> next cycle OutValid=0, InReady=1, C never appears; RetireCount unchanged.
- Retire bundles with flags 0b0010 then 0b1000 -> StickyFlags=0b1010; preload RetireCount to 0xFFFF_FFFF via 2^32-1 retires (or forced) and retire one more -> wraps to 0.
- With OVF_TRAP_EN: bundle PC=0x0040_0010, TrapOvf=1, O=1, RegWrite=1 -> CtrlOut=000, OvfTrap pulses on retire, TrapPC=0x0040_0010; same bundle with TrapOvf=0 -> RegWrite=1, no pulse.

Source files
------------

// File: rtl/alu_result_stage.sv
// Result stage behind the MIPS ALU: two-entry skid buffer with sticky flags and retire counter.
// Define OVF_TRAP_EN to suppress overflow-trapping writebacks and report OvfTrap/TrapPC.
module alu_result_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_W-1:0]     i_alu_out,
  input  logic [3:0]            i_flags_in,
  input  logic [DATA_W-1:0]     i_store_data_in,
  input  logic [DATA_W-1:0]     i_pc_in,
  input  logic [REG_ADDR_W-1:0] i_rd_in,
  input  logic [3:0]            i_ctrl_in,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_W-1:0]     o_result_out,
  output logic [DATA_W-1:0]     o_store_data_out,
  output logic [DATA_W-1:0]     o_pc_out,
  output logic [3:0]            o_flags_out,
  output logic [REG_ADDR_W-1:0] o_rd_out,
  output logic [2:0]            o_ctrl_out,
  output logic [3:0]            o_sticky_flags,
  output logic [CNT_W-1:0]      o_retire_count
`ifdef OVF_TRAP_EN
  ,
  output logic                  o_ovf_trap,
  output logic [DATA_W-1:0]     o_trap_pc
`endif
);

  // Main entry M (drives outputs)
  logic                  r_m_valid;
  logic [DATA_W-1:0]     r_m_result;
  logic [3:0]            r_m_flags;
  logic [DATA_W-1:0]     r_m_store;
  logic [DATA_W-1:0]     r_m_pc;
  logic [REG_ADDR_W-1:0] r_m_rd;
  logic [2:0]            r_m_ctrl;

  // Skid entry K keeps the raw control so trap masking happens on entry to M
  logic                  r_k_valid;
  logic [DATA_W-1:0]     r_k_result;
  logic [3:0]            r_k_flags;
  logic [DATA_W-1:0]     r_k_store;
  logic [DATA_W-1:0]     r_k_pc;
  logic [REG_ADDR_W-1:0] r_k_rd;
  logic [3:0]            r_k_ctrl;

  logic                  r_in_ready;
  logic [3:0]            r_sticky;
  logic [CNT_W-1:0]      r_count;

  logic                  w_accept;
  logic                  w_retire;
  logic                  w_load_m_in;
  logic                  w_load_m_k;
  logic                  w_load_k;
  logic                  w_m_valid_d;
  logic                  w_k_valid_d;

  logic [DATA_W-1:0]     w_src_result;
  logic [3:0]            w_src_flags;
  logic [DATA_W-1:0]     w_src_store;
  logic [DATA_W-1:0]     w_src_pc;
  logic [REG_ADDR_W-1:0] w_src_rd;
  logic [3:0]            w_src_ctrl;
  logic [2:0]            w_src_ctrl_m;

  assign w_accept = i_in_valid & r_in_ready;
  assign w_retire = r_m_valid & i_out_ready;

  always_comb begin
    w_m_valid_d = r_m_valid;
    w_k_valid_d = r_k_valid;
    w_load_m_in = 1'b0;
    w_load_m_k  = 1'b0;
    w_load_k    = 1'b0;
    if (i_flush) begin
      w_m_valid_d = 1'b0;
      w_k_valid_d = 1'b0;
    end else if (r_k_valid) begin
      if (w_retire) begin
        w_load_m_k  = 1'b1;
        w_k_valid_d = 1'b0;
      end
    end else if (r_m_valid) begin
      if (w_accept && w_retire) begin
        w_load_m_in = 1'b1;
      end else if (w_accept) begin
        w_load_k    = 1'b1;
        w_k_valid_d = 1'b1;
      end else if (w_retire) begin
        w_m_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      w_load_m_in = 1'b1;
      w_m_valid_d = 1'b1;
    end
  end

  always_comb begin
    if (w_load_m_k) begin
      w_src_result = r_k_result;
      w_src_flags  = r_k_flags;
      w_src_store  = r_k_store;
      w_src_pc     = r_k_pc;
      w_src_rd     = r_k_rd;
      w_src_ctrl   = r_k_ctrl;
    end else begin
      w_src_result = i_alu_out;
      w_src_flags  = i_flags_in;
      w_src_store  = i_store_data_in;
      w_src_pc     = i_pc_in;
      w_src_rd     = i_rd_in;
      w_src_ctrl   = i_ctrl_in;
    end
  end

`ifdef OVF_TRAP_EN
  logic              w_src_trap;
  logic              r_m_trap;
  logic              r_ovf_trap;
  logic [DATA_W-1:0] r_trap_pc;

  // TrapOvf is ctrl[3], overflow is flags[3]
  assign w_src_trap   = w_src_ctrl[3] & w_src_flags[3];
  assign w_src_ctrl_m = w_src_trap ? 3'b000 : w_src_ctrl[2:0];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_m_trap   <= 1'b0;
      r_ovf_trap <= 1'b0;
      r_trap_pc  <= '0;
    end else begin
      if (w_load_m_in || w_load_m_k) r_m_trap <= w_src_trap;
      r_ovf_trap <= w_retire & r_m_trap;
      if (w_retire && r_m_trap) r_trap_pc <= r_m_pc;
    end
  end

  assign o_ovf_trap = r_ovf_trap;
  assign o_trap_pc  = r_trap_pc;
`else
  logic w_unused_trap_ovf;
  assign w_unused_trap_ovf = w_src_ctrl[3];
  assign w_src_ctrl_m      = w_src_ctrl[2:0];
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_m_valid  <= 1'b0;
      r_k_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_m_result <= '0;
      r_m_flags  <= '0;
      r_m_store  <= '0;
      r_m_pc     <= '0;
      r_m_rd     <= '0;
      r_m_ctrl   <= '0;
      r_k_result <= '0;
      r_k_flags  <= '0;
      r_k_store  <= '0;
      r_k_pc     <= '0;
      r_k_rd     <= '0;
      r_k_ctrl   <= '0;
      r_sticky   <= '0;
      r_count    <= '0;
    end else begin
      r_m_valid  <= w_m_valid_d;
      r_k_valid  <= w_k_valid_d;
      r_in_ready <= ~(w_m_valid_d & w_k_valid_d);
      if (w_load_m_in || w_load_m_k) begin
        r_m_result <= w_src_result;
        r_m_flags  <= w_src_flags;
        r_m_store  <= w_src_store;
        r_m_pc     <= w_src_pc;
        r_m_rd     <= w_src_rd;
        r_m_ctrl   <= w_src_ctrl_m;
      end
      if (w_load_k) begin
        r_k_result <= i_alu_out;
        r_k_flags  <= i_flags_in;
        r_k_store  <= i_store_data_in;
        r_k_pc     <= i_pc_in;
        r_k_rd     <= i_rd_in;
        r_k_ctrl   <= i_ctrl_in;
      end
      // A retire coinciding with flush still counts: downstream already took it
      if (w_retire) begin
        r_sticky <= r_sticky | r_m_flags;
        r_count  <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_in_ready       = r_in_ready;
  assign o_out_valid      = r_m_valid;
  assign o_result_out     = r_m_result;
  assign o_store_data_out = r_m_store;
  assign o_pc_out         = r_m_pc;
  assign o_flags_out      = r_m_flags;
  assign o_rd_out         = r_m_rd;
  assign o_ctrl_out       = r_m_ctrl;
  assign o_sticky_flags   = r_sticky;
  assign o_retire_count   = r_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized bench for alu_result_stage against a queue-based reference model.
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] alu = '0;
  logic [3:0]  flags = '0;
  logic [31:0] store = '0;
  logic [31:0] pc = '0;
  logic [4:0]  rd = '0;
  logic [3:0]  ctrl = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] result_o, store_o, pc_o;
  logic [3:0]  flags_o, sticky_o;
  logic [4:0]  rd_o;
  logic [2:0]  ctrl_o;
  logic [31:0] count_o;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_result_o, s_store_o, s_pc_o;
  logic [3:0]  s_flags_o, s_sticky_o;
  logic [4:0]  s_rd_o;
  logic [2:0]  s_ctrl_o;
  logic [3:0]  s_count_o;
`ifdef OVF_TRAP_EN
  logic        ovf_trap_o, s_ovf_trap_o;
  logic [31:0] trap_pc_o, s_trap_pc_o;
`endif

  always #5 clk = ~clk;

  alu_result_stage dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_alu_out(alu), .i_flags_in(flags), .i_store_data_in(store),
    .i_pc_in(pc), .i_rd_in(rd), .i_ctrl_in(ctrl), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_result_out(result_o), .o_store_data_out(store_o),
    .o_pc_out(pc_o), .o_flags_out(flags_o), .o_rd_out(rd_o), .o_ctrl_out(ctrl_o),
    .o_sticky_flags(sticky_o), .o_retire_count(count_o)
`ifdef OVF_TRAP_EN
    , .o_ovf_trap(ovf_trap_o), .o_trap_pc(trap_pc_o)
`endif
  );

  alu_result_stage #(.CNT_W(4)) dut_small (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(s_in_ready), .i_alu_out(alu), .i_flags_in(flags), .i_store_data_in(store),
    .i_pc_in(pc), .i_rd_in(rd), .i_ctrl_in(ctrl), .o_out_valid(s_out_valid),
    .i_out_ready(out_ready), .o_result_out(s_result_o), .o_store_data_out(s_store_o),
    .o_pc_out(s_pc_o), .o_flags_out(s_flags_o), .o_rd_out(s_rd_o), .o_ctrl_out(s_ctrl_o),
    .o_sticky_flags(s_sticky_o), .o_retire_count(s_count_o)
`ifdef OVF_TRAP_EN
    , .o_ovf_trap(s_ovf_trap_o), .o_trap_pc(s_trap_pc_o)
`endif
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    logic [31:0] store;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
    logic        trap;
  } bundle_t;

  bundle_t     q[$];
  logic        m_ready;
  logic [3:0]  m_sticky;
  logic [31:0] m_count;
  logic        m_trap_pulse;
  logic [31:0] m_trap_pc;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_ready      = 1'b1;
    m_sticky     = '0;
    m_count      = '0;
    m_trap_pulse = 1'b0;
    m_trap_pc    = '0;
  endtask

  task automatic check_outputs();
    check("in_ready", 64'(in_ready), 64'(m_ready));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("result", 64'(result_o), 64'(q[0].result));
      check("flags", 64'(flags_o), 64'(q[0].flags));
      check("store", 64'(store_o), 64'(q[0].store));
      check("pc", 64'(pc_o), 64'(q[0].pc));
      check("rd", 64'(rd_o), 64'(q[0].rd));
      check("ctrl", 64'(ctrl_o), 64'(q[0].ctrl));
    end
    check("sticky", 64'(sticky_o), 64'(m_sticky));
    check("count", 64'(count_o), 64'(m_count));
    check("count_small", 64'(s_count_o), 64'(m_count[3:0]));
`ifdef OVF_TRAP_EN
    check("ovf_trap", 64'(ovf_trap_o), 64'(m_trap_pulse));
    check("trap_pc", 64'(trap_pc_o), 64'(m_trap_pc));
`endif
  endtask

  // Called at a falling edge: check, drive one cycle of stimulus, advance model and clock.
  task automatic step(input logic v, input logic [31:0] a, input logic [3:0] fl,
                      input logic [3:0] c, input logic [31:0] p, input logic [4:0] r,
                      input logic rdy, input logic fls);
    bundle_t b;
    logic    acc, ret;
    check_outputs();
    in_valid  = v;
    alu       = a;
    flags     = fl;
    ctrl      = c;
    pc        = p;
    rd        = r;
    store     = $urandom;
    out_ready = rdy;
    flush     = fls;
    acc = v & m_ready;
    ret = (q.size() != 0) && rdy;
    m_trap_pulse = 1'b0;
    if (ret) begin
      b = q.pop_front();
      m_sticky = m_sticky | b.flags;
      m_count  = m_count + 1;
      if (b.trap) begin
        m_trap_pulse = 1'b1;
        m_trap_pc    = b.pc;
      end
    end
    if (fls) q.delete();
    else if (acc) begin
      b.result = a; b.flags = fl; b.store = store; b.pc = p; b.rd = r;
`ifdef OVF_TRAP_EN
      b.trap = c[3] & fl[3];
`else
      b.trap = 1'b0;
`endif
      b.ctrl = b.trap ? 3'b000 : c[2:0];
      q.push_back(b);
    end
    m_ready = (q.size() < 2);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 5'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_result", 64'(result_o), 64'h0);
    check("rst_store", 64'(store_o), 64'h0);
    check("rst_pc", 64'(pc_o), 64'h0);
    check("rst_flags", 64'(flags_o), 64'h0);
    check("rst_rd", 64'(rd_o), 64'h0);
    check("rst_ctrl", 64'(ctrl_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] saved;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single bundle
    step(1'b1, 32'h5, 4'h0, 4'b0001, 32'h100, 5'd3, 1'b1, 1'b0);
    check("single_result", 64'(result_o), 64'h5);
    check("single_rd", 64'(rd_o), 64'd3);
    idle(1'b1);
    check("single_count", 64'(count_o), 64'd1);

    // Back-to-back stream
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 4'h0, 4'b0001, 32'(i * 4), 5'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Fill to FULL, hold, then drain
    step(1'b1, 32'h11, 4'h0, 4'b0001, 32'h200, 5'd1, 1'b0, 1'b0);
    step(1'b1, 32'h22, 4'h0, 4'b0001, 32'h204, 5'd2, 1'b0, 1'b0);
    idle(1'b0);
    check("full_in_ready", 64'(in_ready), 64'h0);
    check("full_hold", 64'(result_o), 64'h11);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush while FULL with a bundle offered
    step(1'b1, 32'h44, 4'h0, 4'b0001, 32'h300, 5'd4, 1'b0, 1'b0);
    step(1'b1, 32'h55, 4'h0, 4'b0001, 32'h304, 5'd5, 1'b0, 1'b0);
    saved = count_o;
    step(1'b1, 32'h33, 4'h0, 4'b0001, 32'h308, 5'd6, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_ready", 64'(in_ready), 64'h1);
    check("flush_count", 64'(count_o), 64'(saved));
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Sticky flags accumulate
    do_reset();
    step(1'b1, 32'h1, 4'b0010, 4'b0001, 32'h400, 5'd1, 1'b1, 1'b0);
    step(1'b1, 32'h2, 4'b1000, 4'b0001, 32'h404, 5'd2, 1'b1, 1'b0);
    idle(1'b1);
    check("sticky_or", 64'(sticky_o), 64'b1010);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 4'h0, 4'h1, 32'h0, 5'h0, 1'b1, 1'b0);
    idle(1'b1);
    check("wrap_small", 64'(s_count_o), 64'h0);

`ifdef OVF_TRAP_EN
    do_reset();
    step(1'b1, 32'h7fffffff, 4'b1000, 4'b1001, 32'h00400010, 5'd9, 1'b0, 1'b0);
    check("trap_ctrl", 64'(ctrl_o), 64'h0);
    idle(1'b1);
    check("trap_pulse", 64'(ovf_trap_o), 64'h1);
    check("trap_pc_val", 64'(trap_pc_o), 64'h00400010);
    step(1'b1, 32'h7fffffff, 4'b1000, 4'b0001, 32'h00400010, 5'd9, 1'b0, 1'b0);
    check("notrap_pulse_gone", 64'(ovf_trap_o), 64'h0);
    check("notrap_ctrl", 64'(ctrl_o), 64'h1);
    idle(1'b1);
    check("notrap_pulse", 64'(ovf_trap_o), 64'h0);
`endif

    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      step(($urandom % 4) != 0, $urandom, 4'($urandom), 4'($urandom), $urandom,
           5'($urandom), ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
